hmac_msg_pad: RTL and testbench

HMAC_MSG_PAD -- requirements
Module: hmac_msg_pad

---
 rtl/hmac_msg_pad.sv | 158 +++++++++++++++
 tb/tb_hmac_msg_pad.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_msg_pad.sv
// SHA-256 message padder: streams FIFO words, appends 0x80, zero fill and the
// 64-bit bit length so the output is a whole number of 512-bit blocks.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for hash_start_i
// ST_FIFO_RX | passing message words, closing the last partial word
// ST_PAD80   | message ended on a word boundary, emit 0x8000_0000
// ST_PAD00   | zero fill until bit 448 of the current block
// ST_LEN_HI  | emit message_length_i[63:32]
// ST_LEN_LO  | emit message_length_i[31:0], then pulse done_o
module hmac_msg_pad (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sha_en_i,
  input  logic        hash_start_i,
  input  logic [63:0] message_length_i,
  input  logic        fifo_rvalid_i,
  input  logic [35:0] fifo_rdata_i,
  output logic        fifo_rready_o,
  output logic        shaf_rvalid_o,
  output logic [31:0] shaf_rdata_o,
  input  logic        shaf_rready_i,
  output logic        blk_end_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIFO_RX,
    ST_PAD80,
    ST_PAD00,
    ST_LEN_HI,
    ST_LEN_LO
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] tx_count_q, tx_count_d;
  logic        done_q, done_d;

  logic [31:0] fifo_data;
  logic [63:0] remaining;
  logic        msg_done;
  logic        full_word;
  logic [31:0] partial_word;
  logic        valid_c;
  logic        fifo_ready_c;
  logic [31:0] rdata_c;
  logic        unused_mask;

  assign fifo_data   = fifo_rdata_i[35:4];
  assign unused_mask = ^fifo_rdata_i[3:0];

  // Only meaningful in ST_FIFO_RX, where tx_count_q never exceeds the length.
  assign remaining = message_length_i - tx_count_q;
  assign msg_done  = (tx_count_q == message_length_i);
  assign full_word = (remaining >= 64'd32);

  always_comb begin
    partial_word = 32'h0;
    unique case (message_length_i[4:3])
      2'd0: partial_word = 32'h8000_0000;
      2'd1: partial_word = {fifo_data[31:24], 8'h80, 16'h0000};
      2'd2: partial_word = {fifo_data[31:16], 8'h80, 8'h00};
      2'd3: partial_word = {fifo_data[31:8], 8'h80};
      default: partial_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tx_count_d   = tx_count_q;
    done_d       = 1'b0;
    valid_c      = 1'b0;
    fifo_ready_c = 1'b0;
    rdata_c      = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (hash_start_i) begin
          state_d    = ST_FIFO_RX;
          tx_count_d = 64'd0;
        end
      end
      ST_FIFO_RX: begin
        if (msg_done) begin
          state_d = ST_PAD80;
        end else begin
          valid_c      = fifo_rvalid_i;
          fifo_ready_c = shaf_rready_i;
          if (full_word) begin
            rdata_c = fifo_data;
          end else begin
            rdata_c = partial_word;
            if (fifo_rvalid_i && shaf_rready_i) state_d = ST_PAD00;
          end
        end
      end
      ST_PAD80: begin
        valid_c = 1'b1;
        rdata_c = 32'h8000_0000;
        if (shaf_rready_i) state_d = ST_PAD00;
      end
      ST_PAD00: begin
        // The bubble at bit 448 leaves exactly two words for the length.
        if (tx_count_q[8:0] != 9'd448) begin
          valid_c = 1'b1;
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        valid_c = 1'b1;
        rdata_c = message_length_i[63:32];
        if (shaf_rready_i) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        valid_c = 1'b1;
        rdata_c = message_length_i[31:0];
        if (shaf_rready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (valid_c && shaf_rready_i) tx_count_d = tx_count_q + 64'd32;

    if (!sha_en_i) begin
      state_d      = ST_IDLE;
      tx_count_d   = 64'd0;
      done_d       = 1'b0;
      valid_c      = 1'b0;
      fifo_ready_c = 1'b0;
      rdata_c      = 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      tx_count_q <= 64'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_count_q <= tx_count_d;
      done_q     <= done_d;
    end
  end

  assign shaf_rvalid_o = valid_c;
  assign shaf_rdata_o  = rdata_c;
  assign fifo_rready_o = fifo_ready_c;
  assign blk_end_o     = valid_c & (tx_count_q[8:5] == 4'd15);
  assign done_o        = done_q;

endmodule

// File: tb/tb_hmac_msg_pad.sv
// Directed bench for hmac_msg_pad: FIFO model, output collector and
// hand-written expected word sequences for several message lengths.
module tb_hmac_msg_pad;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sha_en;
  logic        hash_start;
  logic [63:0] message_length;
  logic        fifo_rvalid;
  logic [35:0] fifo_rdata;
  logic        fifo_rready;
  logic        shaf_rvalid;
  logic [31:0] shaf_rdata;
  logic        shaf_rready;
  logic        blk_end;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] got_d[$];
  logic        got_b[$];
  logic [31:0] exp_d[$];
  int          done_cnt, done_after, pops, stall_err;
  bit          fin;

  always #5 clk = ~clk;

  hmac_msg_pad dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .sha_en_i        (sha_en),
    .hash_start_i    (hash_start),
    .message_length_i(message_length),
    .fifo_rvalid_i   (fifo_rvalid),
    .fifo_rdata_i    (fifo_rdata),
    .fifo_rready_o   (fifo_rready),
    .shaf_rvalid_o   (shaf_rvalid),
    .shaf_rdata_o    (shaf_rdata),
    .shaf_rready_i   (shaf_rready),
    .blk_end_o       (blk_end),
    .done_o          (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_rvalid = (fifo_q.size() > 0);
    fifo_rdata  = (fifo_q.size() > 0) ? {fifo_q[0], 4'hf} : 36'h0;
  endtask

  task automatic exp_push(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_d.push_back(w);
  endtask

  task automatic start_msg(input logic [63:0] len);
    message_length = len;
    hash_start     = 1'b1;
    @(posedge clk); #1;
    hash_start     = 1'b0;
  endtask

  // Runs one full message; called at posedge+1 with fifo_q preloaded.
  task automatic run_msg(input logic [63:0] len, input bit bp);
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [31:0] tmp;
    logic        popnow;
    got_d.delete();
    got_b.delete();
    done_cnt = 0; done_after = 0; pops = 0; stall_err = 0; fin = 0;
    prev_stall = 1'b0; prev_data = 32'h0;
    drive_fifo();
    shaf_rready = 1'b1;
    start_msg(len);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      shaf_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) begin done_cnt++; fin = 1; end
      if (prev_stall && (!shaf_rvalid || shaf_rdata !== prev_data)) stall_err++;
      prev_stall = shaf_rvalid && !shaf_rready;
      prev_data  = shaf_rdata;
      if (shaf_rvalid && shaf_rready) begin
        got_d.push_back(shaf_rdata);
        got_b.push_back(blk_end);
      end
      popnow = fifo_rvalid && fifo_rready;
      @(posedge clk); #1;
      if (popnow) begin
        pops++;
        if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
      end
      drive_fifo();
    end
    shaf_rready = 1'b1;
    @(negedge clk);
    if (done) done_after++;
    @(posedge clk); #1;
  endtask

  task automatic check_run(input string tag, input int nwords);
    int n;
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_one_cycle"}, 64'(done_after), 64'd0);
    chk({tag, "_fifo_pops"}, 64'(pops), 64'(nwords));
    chk({tag, "_stall_stable"}, 64'(stall_err), 64'd0);
    chk({tag, "_word_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      chk($sformatf("%s_blk_end%0d", tag, i), 64'(got_b[i]), 64'((i % 16) == 15));
    end
  endtask

  task automatic exp_len24();
    exp_d.delete();
    exp_push(32'h6162_6380, 1);
    exp_push(32'h0, 14);
    exp_push(32'h0000_0018, 1);
  endtask

  task automatic idle_watch(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (shaf_rvalid || done || fifo_rready) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; sha_en = 1'b1; hash_start = 1'b0; message_length = 64'd0;
    fifo_rvalid = 1'b0; fifo_rdata = 36'h0; shaf_rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(shaf_rvalid), 64'd0);
    chk("rst_rdata", 64'(shaf_rdata), 64'd0);
    chk("rst_fifo_rready", 64'(fifo_rready), 64'd0);
    chk("rst_blk_end", 64'(blk_end), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty message
    fifo_q.delete();
    exp_d.delete();
    exp_push(32'h8000_0000, 1);
    exp_push(32'h0, 15);
    run_msg(64'd0, 1'b0);
    check_run("len0", 0);

    // "abc"
    fifo_q = '{32'h6162_6300};
    exp_len24();
    run_msg(64'd24, 1'b0);
    check_run("len24", 1);

    // 55 bytes: last word carries 3 data bytes plus 0x80
    fifo_q.delete();
    exp_d.delete();
    for (int i = 0; i < 14; i++) fifo_q.push_back(32'h1020_3040 + 32'(i));
    for (int i = 0; i < 13; i++) exp_d.push_back(32'h1020_3040 + 32'(i));
    exp_push(32'h1020_3080, 1);
    exp_push(32'h0, 1);
    exp_push(32'h0000_01b8, 1);
    run_msg(64'd440, 1'b0);
    check_run("len440", 14);

    // 56 bytes: length no longer fits, spills into a second block
    fifo_q.delete();
    exp_d.delete();
    for (int i = 0; i < 14; i++) fifo_q.push_back(32'ha5a5_0000 + 32'(i));
    for (int i = 0; i < 14; i++) exp_d.push_back(32'ha5a5_0000 + 32'(i));
    exp_push(32'h8000_0000, 1);
    exp_push(32'h0, 16);
    exp_push(32'h0000_01c0, 1);
    run_msg(64'd448, 1'b0);
    check_run("len448", 14);

    // "abc" with random backpressure
    fifo_q = '{32'h6162_6300};
    exp_len24();
    run_msg(64'd24, 1'b1);
    check_run("len24_bp", 1);

    // sha_en dropped while zero filling
    fifo_q = '{32'h6162_6300};
    drive_fifo();
    start_msg(64'd24);
    repeat (6) @(posedge clk);
    #1;
    fifo_q.delete();
    drive_fifo();
    sha_en = 1'b0;
    @(posedge clk); #1;
    sha_en = 1'b1;
    @(negedge clk);
    chk("abort_en_valid", 64'(shaf_rvalid), 64'd0);
    chk("abort_en_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    idle_watch("abort_en_quiet");
    fifo_q = '{32'h6162_6300};
    exp_len24();
    run_msg(64'd24, 1'b0);
    check_run("restart_en", 1);

    // Reset asserted while zero filling
    fifo_q = '{32'h6162_6300};
    drive_fifo();
    start_msg(64'd24);
    repeat (6) @(posedge clk);
    #1;
    fifo_q.delete();
    drive_fifo();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_valid", 64'(shaf_rvalid), 64'd0);
    chk("abort_rst_rdata", 64'(shaf_rdata), 64'd0);
    chk("abort_rst_blk_end", 64'(blk_end), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_watch("abort_rst_quiet");
    fifo_q = '{32'h6162_6300};
    exp_len24();
    run_msg(64'd24, 1'b0);
    check_run("restart_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
